// File: rtl/sub_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sub_parser_pkg
// Description : Shared definitions for the multi-lane container extractor.
//               Holds the parse-action field layout, container type codes,
//               the FSM state encoding and the type -> byte-width mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package sub_parser_pkg;

   // Container type codes carried in the action's type field
   localparam logic [1:0] TYPE_1B = 2'b00;
   localparam logic [1:0] TYPE_2B = 2'b01;
   localparam logic [1:0] TYPE_4B = 2'b10;
   localparam logic [1:0] TYPE_6B = 2'b11;

   // Parse-action field layout (offset width is a module parameter)
   localparam int ACT_EN       = 0;
   localparam int ACT_SEQ_LSB  = 1;
   localparam int ACT_SEQ_W    = 6;
   localparam int ACT_TYPE_LSB = 7;
   localparam int ACT_TYPE_W   = 2;
   localparam int ACT_OFF_LSB  = 9;

   // Widest container that can be extracted, in bytes
   localparam int MAX_BYTES    = 6;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Byte width of a container for a given type code
   function automatic logic [2:0] type_bytes(input logic [1:0] t);
      case (t)
         TYPE_1B: return 3'd1;
         TYPE_2B: return 3'd2;
         TYPE_4B: return 3'd4;
         default: return 3'd6;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/sub_parser_lane.sv
`default_nettype none
// ============================================================================
// Module      : sub_parser_lane
// Description : Combinational decode of one parse action against the packet
//               header. Produces the zero-extended container value plus its
//               type, sequence number, lane-valid and out-of-bounds flag.
// Ports       : pkts_hdr   - latched packet header, byte k at [8k+7:8k]
//               act        - one parse action
//               value      - extracted container, zero-extended
//               vtype      - container type code
//               seq        - container sequence number
//               lane_valid - action is enabled
//               err        - action reaches past the end of the header
// Revision    : 1.0 - initial release
// ============================================================================
module sub_parser_lane
   import sub_parser_pkg::*;
#(
   parameter int PKTS_HDR_LEN  = 4096,
   parameter int PARSE_ACT_LEN = 24,
   parameter int VAL_OUT_LEN   = 48,
   parameter int OFF_W         = 9
) (
   input  logic [PKTS_HDR_LEN-1:0]  pkts_hdr,
   input  logic [PARSE_ACT_LEN-1:0] act,
   output logic [VAL_OUT_LEN-1:0]   value,
   output logic [1:0]               vtype,
   output logic [5:0]               seq,
   output logic                     lane_valid,
   output logic                     err
);

   localparam int HDR_BYTES = PKTS_HDR_LEN / 8;
   // Wide enough to hold offset + 6 and the header byte count without wrap
   localparam int SUM_W = (($clog2(HDR_BYTES + 1) > OFF_W) ? $clog2(HDR_BYTES + 1) : OFF_W) + 2;

   logic [OFF_W-1:0] w_off;
   logic [1:0]       w_type;
   logic [2:0]       w_nbytes;
   logic             w_in_bounds;

   assign w_off       = act[ACT_OFF_LSB +: OFF_W];
   assign w_type      = act[ACT_TYPE_LSB +: ACT_TYPE_W];
   assign w_nbytes    = type_bytes(w_type);
   assign w_in_bounds = (SUM_W'(w_off) + SUM_W'(w_nbytes)) <= SUM_W'(HDR_BYTES);

   always_comb begin
      value      = '0;
      vtype      = '0;
      seq        = '0;
      lane_valid = 1'b0;
      err        = 1'b0;
      if (act[ACT_EN]) begin
         lane_valid = 1'b1;
         vtype      = w_type;
         seq        = act[ACT_SEQ_LSB +: ACT_SEQ_W];
         if (!w_in_bounds) begin
            err = 1'b1;
         end else begin
            // In bounds guarantees every selected byte lies inside the header
            for (int k = 0; k < MAX_BYTES; k++) begin
               if (k < int'(w_nbytes)) begin
                  value[k*8 +: 8] = pkts_hdr[(int'(w_off) + k)*8 +: 8];
               end
            end
         end
      end
   end

   // Action bits above the offset field carry no meaning here
   generate
      if (PARSE_ACT_LEN > ACT_OFF_LSB + OFF_W) begin : g_spare
         logic w_unused_spare;
         assign w_unused_spare = ^act[PARSE_ACT_LEN-1:ACT_OFF_LSB+OFF_W];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/sub_parser_mlane.sv
`default_nettype none
// ============================================================================
// Module      : sub_parser_mlane
// Description : Multi-lane container extractor. Latches one header plus
//               NUM_ACTS parse actions, then emits ceil(NUM_ACTS/LANES) beats
//               of LANES containers each under valid/ready handshaking.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               in_valid/in_ready      - packet input handshake
//               pkts_hdr, parse_acts   - header and action vector
//               out_valid/out_ready    - beat output handshake
//               val_out, val_out_type, val_out_seq,
//               val_out_lane_valid, val_out_err - per-lane beat fields
//               out_last               - final beat of the packet
//               busy                   - packet in flight
// Revision    : 1.0 - initial release
// ============================================================================
module sub_parser_mlane
   import sub_parser_pkg::*;
#(
   parameter int PKTS_HDR_LEN  = 4096,
   parameter int PARSE_ACT_LEN = 24,
   parameter int VAL_OUT_LEN   = 48,
   parameter int NUM_ACTS      = 10,
   parameter int LANES         = 2,
   parameter int OFF_W         = 9
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [PKTS_HDR_LEN-1:0]           pkts_hdr,
   input  logic [NUM_ACTS*PARSE_ACT_LEN-1:0] parse_acts,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [LANES*VAL_OUT_LEN-1:0]      val_out,
   output logic [LANES*2-1:0]                val_out_type,
   output logic [LANES*6-1:0]                val_out_seq,
   output logic [LANES-1:0]                  val_out_lane_valid,
   output logic [LANES-1:0]                  val_out_err,
   output logic                              out_last,
   output logic                              busy
);

   localparam int NBEATS  = (NUM_ACTS + LANES - 1) / LANES;
   localparam int IDX_W   = $clog2(NBEATS + 1);
   localparam int GROUP_W = LANES * PARSE_ACT_LEN;
   localparam int ACTS_W  = NUM_ACTS * PARSE_ACT_LEN;
   localparam int PAD_W   = NBEATS * GROUP_W - ACTS_W;

   localparam logic [IDX_W-1:0] C_NBEATS   = IDX_W'(NBEATS);
   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NBEATS - 1);

   state_t                      r_state;
   state_t                      w_state_next;
   logic [PKTS_HDR_LEN-1:0]     r_hdr;
   logic [ACTS_W-1:0]           r_acts;
   logic [IDX_W-1:0]            r_idx;
   logic                        w_accept;
   logic                        w_load;

   logic                        r_valid;
   logic                        r_last;
   logic [LANES*VAL_OUT_LEN-1:0] r_val;
   logic [LANES*2-1:0]          r_type;
   logic [LANES*6-1:0]          r_seq;
   logic [LANES-1:0]            r_lv;
   logic [LANES-1:0]            r_err;

   // Actions padded with disabled entries so the final partial group
   // decodes its missing lanes as all-zero
   logic [NBEATS*GROUP_W-1:0]   w_acts_pad;
   logic [IDX_W-1:0]            w_grp_idx;
   logic [GROUP_W-1:0]          w_group;

   logic [LANES*VAL_OUT_LEN-1:0] w_val;
   logic [LANES*2-1:0]          w_type;
   logic [LANES*6-1:0]          w_seq;
   logic [LANES-1:0]            w_lv;
   logic [LANES-1:0]            w_err;

   generate
      if (PAD_W > 0) begin : g_pad
         assign w_acts_pad = {{PAD_W{1'b0}}, r_acts};
      end else begin : g_nopad
         assign w_acts_pad = r_acts;
      end
   endgenerate

   // Clamp keeps the group select in range once every beat is loaded
   assign w_grp_idx = (r_idx < C_NBEATS) ? r_idx : '0;
   assign w_group   = w_acts_pad[int'(w_grp_idx)*GROUP_W +: GROUP_W];

   generate
      for (genvar j = 0; j < LANES; j++) begin : g_lane
         sub_parser_lane #(
            .PKTS_HDR_LEN  (PKTS_HDR_LEN),
            .PARSE_ACT_LEN (PARSE_ACT_LEN),
            .VAL_OUT_LEN   (VAL_OUT_LEN),
            .OFF_W         (OFF_W)
         ) u_lane (
            .pkts_hdr   (r_hdr),
            .act        (w_group[j*PARSE_ACT_LEN +: PARSE_ACT_LEN]),
            .value      (w_val[j*VAL_OUT_LEN +: VAL_OUT_LEN]),
            .vtype      (w_type[j*2 +: 2]),
            .seq        (w_seq[j*6 +: 6]),
            .lane_valid (w_lv[j]),
            .err        (w_err[j])
         );
      end
   endgenerate

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_load       = 1'b0;
      in_ready     = 1'b0;
      busy         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Held low while rst is asserted so nothing is offered mid-reset
            in_ready = !rst;
            if (in_valid && !rst) begin
               w_accept     = 1'b1;
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            busy   = 1'b1;
            w_load = (!r_valid || out_ready) && (r_idx < C_NBEATS);
            if (r_valid && out_ready && r_last) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_hdr   <= '0;
         r_acts  <= '0;
         r_idx   <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_val   <= '0;
         r_type  <= '0;
         r_seq   <= '0;
         r_lv    <= '0;
         r_err   <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_hdr  <= pkts_hdr;
            r_acts <= parse_acts;
            r_idx  <= '0;
         end
         if (w_load) begin
            r_valid <= 1'b1;
            r_last  <= (r_idx == C_LAST_IDX);
            r_val   <= w_val;
            r_type  <= w_type;
            r_seq   <= w_seq;
            r_lv    <= w_lv;
            r_err   <= w_err;
            r_idx   <= r_idx + IDX_W'(1);
         end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign out_valid          = r_valid;
   assign out_last           = r_last;
   assign val_out            = r_val;
   assign val_out_type       = r_type;
   assign val_out_seq        = r_seq;
   assign val_out_lane_valid = r_lv;
   assign val_out_err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sub_parser_mlane.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub_parser_mlane
// Description : Self-checking bench for sub_parser_mlane. Directed packets
//               from the container examples plus randomized headers/actions
//               and randomized backpressure, scored against a byte-level
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_parser_mlane;

   localparam int HL  = 4096;
   localparam int PAL = 24;
   localparam int VL  = 48;
   localparam int NA  = 10;
   localparam int LN  = 2;
   localparam int OW  = 9;
   localparam int NB  = (NA + LN - 1) / LN;

   typedef struct packed {
      logic [VL-1:0] val;
      logic [1:0]    typ;
      logic [5:0]    seq;
      logic          lv;
      logic          err;
   } lane_t;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic [HL-1:0]       pkts_hdr;
   logic [NA*PAL-1:0]   parse_acts;
   logic                out_valid;
   logic                out_ready;
   logic [LN*VL-1:0]    val_out;
   logic [LN*2-1:0]     val_out_type;
   logic [LN*6-1:0]     val_out_seq;
   logic [LN-1:0]       val_out_lane_valid;
   logic [LN-1:0]       val_out_err;
   logic                out_last;
   logic                busy;

   int checks = 0;
   int errors = 0;

   logic [HL-1:0]       cur_hdr;
   logic [NA*PAL-1:0]   cur_acts;
   lane_t               cap [NB][LN];
   logic                cap_last [NB];

   always #5 clk = ~clk;

   sub_parser_mlane #(
      .PKTS_HDR_LEN  (HL),
      .PARSE_ACT_LEN (PAL),
      .VAL_OUT_LEN   (VL),
      .NUM_ACTS      (NA),
      .LANES         (LN),
      .OFF_W         (OW)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .pkts_hdr           (pkts_hdr),
      .parse_acts         (parse_acts),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .val_out            (val_out),
      .val_out_type       (val_out_type),
      .val_out_seq        (val_out_seq),
      .val_out_lane_valid (val_out_lane_valid),
      .val_out_err        (val_out_err),
      .out_last           (out_last),
      .busy               (busy)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: container = header bytes off..off+n-1, little-endian
   function automatic lane_t ref_lane(input logic [HL-1:0] h, input logic [PAL-1:0] a);
      lane_t r;
      int    nb;
      int    off;
      logic [1:0] t;
      r = '0;
      if (a[0]) begin
         t     = a[8:7];
         r.lv  = 1'b1;
         r.typ = t;
         r.seq = a[6:1];
         nb    = (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : (t == 2'd2) ? 4 : 6;
         off   = int'(a[17:9]);
         if ((off + nb) * 8 > HL) begin
            r.err = 1'b1;
         end else begin
            for (int k = 0; k < nb; k++) begin
               r.val = r.val | (VL'(h[(off + k)*8 +: 8]) << (8*k));
            end
         end
      end
      return r;
   endfunction

   function automatic lane_t exp_lane(input int b, input int j);
      int i;
      i = b*LN + j;
      if (i >= NA) return '0;
      return ref_lane(cur_hdr, cur_acts[i*PAL +: PAL]);
   endfunction

   function automatic logic [PAL-1:0] mk_act(input bit en, input int sq, input int typ, input int off);
      logic [PAL-1:0] a;
      a      = '0;
      a[0]   = en;
      a[6:1] = 6'(sq);
      a[8:7] = 2'(typ);
      a[17:9] = 9'(off);
      return a;
   endfunction

   function automatic logic [HL-1:0] rand_hdr();
      logic [HL-1:0] h;
      for (int k = 0; k < HL/32; k++) h[k*32 +: 32] = $urandom;
      return h;
   endfunction

   function automatic logic [NA*PAL-1:0] rand_acts();
      logic [NA*PAL-1:0] a;
      logic [PAL-1:0]    x;
      for (int i = 0; i < NA; i++) begin
         x = PAL'($urandom);
         // Bias half the offsets toward the header tail to exercise bounds
         x[17:9] = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 511))
                                               : 9'($urandom_range(500, 511));
         a[i*PAL +: PAL] = x;
      end
      return a;
   endfunction

   // Called at a negedge; returns at the negedge of the cycle after accept
   task automatic send(input logic [HL-1:0] h, input logic [NA*PAL-1:0] a);
      int w;
      w = 0;
      cur_hdr  = h;
      cur_acts = a;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("in_ready_wait", in_ready, 1);
      pkts_hdr   = h;
      parse_acts = a;
      in_valid   = 1'b1;
      @(negedge clk);
      in_valid   = 1'b0;
      pkts_hdr   = rand_hdr();
      chk("busy_after_accept", busy, 1);
      chk("in_ready_while_busy", in_ready, 0);
      chk("no_early_valid", out_valid, 0);
   endtask

   task automatic drain(input int stall_beat, input bit rand_ready, input int abort_beat);
      int    b, cyc, stall;
      bit    held, seen, aborted;
      bit    rdy;
      lane_t e;
      logic [LN*VL-1:0] ev, hv;
      logic [LN*2-1:0]  et, ht;
      logic [LN*6-1:0]  es, hs;
      logic [LN-1:0]    el, ee, hl, he;
      logic             hlast;
      b = 0; cyc = 0; stall = 0; held = 0; seen = 0; aborted = 0;
      while (b < NB && cyc < 300 && !aborted) begin
         if (held) begin
            chk("stall_valid_held", out_valid, 1);
            chk("stall_val",  val_out, hv);
            chk("stall_type", val_out_type, ht);
            chk("stall_seq",  val_out_seq, hs);
            chk("stall_lv",   val_out_lane_valid, hl);
            chk("stall_err",  val_out_err, he);
            chk("stall_last", out_last, hlast);
         end
         if (!rand_ready && b > 0) chk("no_bubble", out_valid, 1);
         if (out_valid) begin
            if (!seen) begin
               chk("first_beat_latency", cyc, 1);
               seen = 1;
            end
            if (b == abort_beat) begin
               aborted = 1;
            end else begin
               rdy = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
               if (b == stall_beat && stall < 3) begin
                  rdy = 1'b0;
                  stall++;
               end
               out_ready = rdy;
               if (rdy) begin
                  for (int j = 0; j < LN; j++) begin
                     e = exp_lane(b, j);
                     ev[j*VL +: VL] = e.val;
                     et[j*2 +: 2]   = e.typ;
                     es[j*6 +: 6]   = e.seq;
                     el[j]          = e.lv;
                     ee[j]          = e.err;
                     cap[b][j].val  = val_out[j*VL +: VL];
                     cap[b][j].typ  = val_out_type[j*2 +: 2];
                     cap[b][j].seq  = val_out_seq[j*6 +: 6];
                     cap[b][j].lv   = val_out_lane_valid[j];
                     cap[b][j].err  = val_out_err[j];
                  end
                  cap_last[b] = out_last;
                  chk($sformatf("b%0d_val", b),  val_out, ev);
                  chk($sformatf("b%0d_type", b), val_out_type, et);
                  chk($sformatf("b%0d_seq", b),  val_out_seq, es);
                  chk($sformatf("b%0d_lv", b),   val_out_lane_valid, el);
                  chk($sformatf("b%0d_err", b),  val_out_err, ee);
                  chk($sformatf("b%0d_last", b), out_last, (b == NB-1));
                  b++;
                  held = 0;
               end else begin
                  held = 1;
                  hv = val_out; ht = val_out_type; hs = val_out_seq;
                  hl = val_out_lane_valid; he = val_out_err; hlast = out_last;
               end
            end
         end else begin
            out_ready = ($urandom_range(0, 1) == 1);
            held = 0;
         end
         if (!aborted) begin
            @(negedge clk);
            cyc++;
         end
      end
      if (!aborted) begin
         out_ready = 1'b0;
         chk("beats_all_seen", b, NB);
         chk("valid_drop_after_last", out_valid, 0);
         chk("in_ready_after_last", in_ready, 1);
         chk("busy_after_last", busy, 0);
      end
   endtask

   initial begin
      logic [NA*PAL-1:0] a;
      logic [HL-1:0]     h;

      rst        = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      pkts_hdr   = '0;
      parse_acts = '0;

      // Reset state
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_val_out", val_out, 0);
      chk("rst_out_last", out_last, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_busy", busy, 0);

      // Directed extraction: header bytes k = k
      h = '0;
      for (int k = 0; k < 16; k++) h[k*8 +: 8] = 8'(k);
      a = '0;
      a[0*PAL +: PAL] = mk_act(1, 3, 1, 4);
      a[1*PAL +: PAL] = mk_act(1, 5, 3, 2);
      a[2*PAL +: PAL] = mk_act(1, 7, 0, 15);
      send(h, a);
      drain(-1, 0, -1);
      chk("ex_b0l0_val", cap[0][0].val, 48'h0504);
      chk("ex_b0l0_type", cap[0][0].typ, 2'b01);
      chk("ex_b0l0_seq", cap[0][0].seq, 6'd3);
      chk("ex_b0l0_lv", cap[0][0].lv, 1);
      chk("ex_b0l1_val", cap[0][1].val, 48'h070605040302);
      chk("ex_b1l0_val", cap[1][0].val, 48'h0F);
      chk("ex_b1l1_lv", cap[1][1].lv, 0);
      chk("ex_b0_last", cap_last[0], 0);
      chk("ex_b4_last", cap_last[NB-1], 1);

      // Bounds: 4B at 510 errs, 6B ending exactly at 512 does not
      h = rand_hdr();
      a = '0;
      a[0*PAL +: PAL] = mk_act(1, 9, 2, 510);
      a[1*PAL +: PAL] = mk_act(1, 10, 3, 506);
      a[2*PAL +: PAL] = mk_act(1, 11, 0, 511);
      a[3*PAL +: PAL] = mk_act(1, 12, 1, 511);
      send(h, a);
      drain(1, 0, -1);
      chk("oob_b0l0_err", cap[0][0].err, 1);
      chk("oob_b0l0_val", cap[0][0].val, 0);
      chk("oob_b0l0_lv", cap[0][0].lv, 1);
      chk("oob_b0l1_err", cap[0][1].err, 0);
      chk("oob_b1l0_err", cap[1][0].err, 0);
      chk("oob_b1l1_err", cap[1][1].err, 1);

      // Randomized packets, back-to-back, with random backpressure
      for (int p = 0; p < 12; p++) begin
         send(rand_hdr(), rand_acts());
         drain(-1, 1, -1);
      end

      // Reset during beat 2 drops the packet
      send(rand_hdr(), rand_acts());
      drain(-1, 0, 2);
      out_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_in_ready_in_rst", in_ready, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_in_ready_after", in_ready, 1);
      chk("abort_no_partial", out_valid, 0);
      send(rand_hdr(), rand_acts());
      drain(-1, 0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
